caf_argmax_ctrl: RTL and testbench

- Sequencer for the CAF peak search.
- Steps through `freq_bins` frequency bins of `buffer_length` complex correlation samples each, computing per-sample magnitude (I²/2 + Q²/2).
- Tracks the peak within each bin, then the global peak across bins.
- Reports the global peak magnitude with its time index and frequency-bin index via a valid/ready result handshake.
- Sits between the correlator output stream and the CAF result consumer.

---
 rtl/caf_argmax_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_caf_argmax_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/caf_argmax_ctrl.sv
// CAF peak-search sequencer: per-sample magnitude, per-bin and global
// argmax, result returned over a valid/ready handshake.
module caf_argmax_ctrl #(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int freq_bins     = 8,
  parameter int freq_bits     = 3,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12,
  parameter int out_max_bits  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     m_axis_tvalid,
  input  logic signed [i_bits-1:0] xi,
  input  logic signed [q_bits-1:0] xq,
  output logic                     s_axis_tready,
  input  logic                     m_axis_tready,
  output logic                     s_axis_tvalid,
  output logic [out_max_bits-1:0]  out_max,
  output logic [index_bits-1:0]    index,
  output logic [freq_bits-1:0]     freq_index,
  output logic                     busy
);

  localparam int CW    = index_bits + 1;
  localparam int ISQ_W = 2 * i_bits - 1;
  localparam int QSQ_W = 2 * q_bits - 1;

  typedef enum logic [2:0] {
    IDLE, RUN, FLUSH, BIN_END, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           samp_q, samp_d;
  logic [freq_bits-1:0]    bin_q, bin_d;
  logic                    flush_q, flush_d;
  logic                    s1_vld_q, s1_vld_d;
  logic [ISQ_W-1:0]        isq_q, isq_d;
  logic [QSQ_W-1:0]        qsq_q, qsq_d;
  logic [index_bits-1:0]   s1_idx_q, s1_idx_d;
  logic                    s2_vld_q, s2_vld_d;
  logic [out_max_bits-1:0] mag_q, mag_d;
  logic [index_bits-1:0]   s2_idx_q, s2_idx_d;
  logic [out_max_bits-1:0] bmax_q, bmax_d;
  logic [index_bits-1:0]   bidx_q, bidx_d;
  logic [out_max_bits-1:0] gmax_q, gmax_d;
  logic [index_bits-1:0]   gidx_q, gidx_d;
  logic [freq_bits-1:0]    gfrq_q, gfrq_d;

  logic signed [2*i_bits-1:0] ip;
  logic signed [2*q_bits-1:0] qp;
  logic                       accept;

  assign ip = xi * xi;
  assign qp = xq * xq;

  assign s_axis_tready = (state_q == RUN) &&
                         (samp_q < CW'(buffer_length));
  assign accept        = s_axis_tready && m_axis_tvalid;
  assign s_axis_tvalid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign out_max       = gmax_q;
  assign index         = gidx_q;
  assign freq_index    = gfrq_q;

  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    bin_d    = bin_q;
    flush_d  = flush_q;
    s1_vld_d = accept;
    isq_d    = isq_q;
    qsq_d    = qsq_q;
    s1_idx_d = s1_idx_q;
    s2_vld_d = s1_vld_q;
    mag_d    = mag_q;
    s2_idx_d = s2_idx_q;
    bmax_d   = bmax_q;
    bidx_d   = bidx_q;
    gmax_d   = gmax_q;
    gidx_d   = gidx_q;
    gfrq_d   = gfrq_q;

    if (accept) begin
      isq_d    = ISQ_W'($unsigned(ip));
      qsq_d    = QSQ_W'($unsigned(qp));
      s1_idx_d = samp_q[index_bits-1:0];
      samp_d   = samp_q + CW'(1);
    end
    if (s1_vld_q) begin
      mag_d    = out_max_bits'(isq_q >> 1) +
                 out_max_bits'(qsq_q >> 1);
      s2_idx_d = s1_idx_q;
    end
    // strict compare keeps the earliest sample on ties
    if (s2_vld_q && (mag_q > bmax_q)) begin
      bmax_d = mag_q;
      bidx_d = s2_idx_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          samp_d  = '0;
          bin_d   = '0;
          bmax_d  = '0;
          bidx_d  = '0;
          gmax_d  = '0;
          gidx_d  = '0;
          gfrq_d  = '0;
        end
      end
      RUN: begin
        if (accept && (samp_q == CW'(buffer_length - 1))) begin
          state_d = FLUSH;
          flush_d = 1'b0;
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) begin
          state_d = BIN_END;
          flush_d = 1'b0;
        end
      end
      BIN_END: begin
        if (bmax_q > gmax_q) begin
          gmax_d = bmax_q;
          gidx_d = bidx_q;
          gfrq_d = bin_q;
        end
        if (bin_q == freq_bits'(freq_bins - 1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          bin_d   = bin_q + freq_bits'(1);
          samp_d  = '0;
          bmax_d  = '0;
          bidx_d  = '0;
        end
      end
      DONE: begin
        if (m_axis_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      samp_q   <= '0;
      bin_q    <= '0;
      flush_q  <= 1'b0;
      s1_vld_q <= 1'b0;
      isq_q    <= '0;
      qsq_q    <= '0;
      s1_idx_q <= '0;
      s2_vld_q <= 1'b0;
      mag_q    <= '0;
      s2_idx_q <= '0;
      bmax_q   <= '0;
      bidx_q   <= '0;
      gmax_q   <= '0;
      gidx_q   <= '0;
      gfrq_q   <= '0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      bin_q    <= bin_d;
      flush_q  <= flush_d;
      s1_vld_q <= s1_vld_d;
      isq_q    <= isq_d;
      qsq_q    <= qsq_d;
      s1_idx_q <= s1_idx_d;
      s2_vld_q <= s2_vld_d;
      mag_q    <= mag_d;
      s2_idx_q <= s2_idx_d;
      bmax_q   <= bmax_d;
      bidx_q   <= bidx_d;
      gmax_q   <= gmax_d;
      gidx_q   <= gidx_d;
      gfrq_q   <= gfrq_d;
    end
  end

endmodule

// File: tb/tb_caf_argmax_ctrl.sv
// Bench for caf_argmax_ctrl: table of sparse sweeps scored through an
// expected-result queue, plus reset, latency and start-while-busy cases.
module tb_caf_argmax_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               m_axis_tvalid;
  logic signed [11:0] xi;
  logic signed [11:0] xq;
  logic               s_axis_tready;
  logic               m_axis_tready;
  logic               s_axis_tvalid;
  logic [23:0]        out_max;
  logic [3:0]         index;
  logic [2:0]         freq_index;
  logic               busy;

  caf_argmax_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .m_axis_tvalid(m_axis_tvalid),
    .xi           (xi),
    .xq           (xq),
    .s_axis_tready(s_axis_tready),
    .m_axis_tready(m_axis_tready),
    .s_axis_tvalid(s_axis_tvalid),
    .out_max      (out_max),
    .index        (index),
    .freq_index   (freq_index),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int b0; int s0; int i0; int q0;
    int b1; int s1; int i1; int q1;
    int b2; int s2; int i2; int q2;
    int em; int ei; int ef;
    bit gaps; int stall;
  } vec_t;

  typedef struct packed {
    logic [23:0] m;
    logic [3:0]  i;
    logic [2:0]  f;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    int b0, int s0, int i0, int q0,
    int b1, int s1, int i1, int q1,
    int b2, int s2, int i2, int q2,
    int em, int ei, int ef, bit g, int st);
    vec_t v;
    v.b0 = b0; v.s0 = s0; v.i0 = i0; v.q0 = q0;
    v.b1 = b1; v.s1 = s1; v.i1 = i1; v.q1 = q1;
    v.b2 = b2; v.s2 = s2; v.i2 = i2; v.q2 = q2;
    v.em = em; v.ei = ei; v.ef = ef;
    v.gaps = g; v.stall = st;
    return v;
  endfunction

  task automatic get_xy(input vec_t v, input int b, input int s,
                        output int x, output int y);
    x = 0; y = 0;
    if (b == v.b0 && s == v.s0) begin
      x = v.i0; y = v.q0;
    end else if (b == v.b1 && s == v.s1) begin
      x = v.i1; y = v.q1;
    end else if (b == v.b2 && s == v.s2) begin
      x = v.i2; y = v.q2;
    end
  endtask

  task automatic run_sweep(input vec_t v, input int abort_bin,
                           input bit zlat, input string nm);
    int   t0, w, bad, x, y;
    bit   acc, got;
    exp_t e;
    logic [30:0] hold;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    if (abort_bin < 0) begin
      e.m = 24'(v.em); e.i = 4'(v.ei); e.f = 3'(v.ef);
      sb.push_back(e);
    end
    for (int b = 0; b < 8; b++) begin
      for (int s = 0; s < 10; s++) begin
        if (b == abort_bin && s == 4) begin
          m_axis_tvalid = 1'b0;
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          @(negedge clk);
          chk({nm, "_rst_outs"},
              {s_axis_tready, s_axis_tvalid, out_max, index,
               freq_index, busy}, 0);
          return;
        end
        if (v.gaps) begin
          repeat ($urandom_range(0, 2)) begin
            m_axis_tvalid = 1'b0;
            @(posedge clk); #1;
          end
        end
        get_xy(v, b, s, x, y);
        m_axis_tvalid = 1'b1;
        xi = 12'(x);
        xq = 12'(y);
        start = zlat && (b == 2) && (s == 5);
        w = 0;
        do begin
          @(negedge clk);
          acc = s_axis_tready;
          @(posedge clk); #1;
          w++;
        end while (!acc && w < 20);
        start = 1'b0;
        if (!acc) begin
          chk({nm, "_accept_timeout"}, 0, 1);
          return;
        end
      end
    end
    m_axis_tvalid = 1'b0;
    xi = '0;
    xq = '0;
    w = 0; bad = 0;
    do begin
      @(negedge clk);
      got = s_axis_tvalid;
      if (s_axis_tready) bad++;
      if (!got) begin
        @(posedge clk); #1;
        w++;
      end
    end while (!got && w < 40);
    if (!got) begin
      chk({nm, "_tvalid_timeout"}, 0, 1);
      return;
    end
    if (zlat) chk({nm, "_latency"}, cyc - t0, 104);
    hold = {out_max, index, freq_index};
    for (int k = 0; k < v.stall; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!s_axis_tvalid || s_axis_tready ||
          {out_max, index, freq_index} != hold) bad++;
    end
    chk({nm, "_tready_low_stable"}, bad, 0);
    m_axis_tready = 1'b1;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_out_max"}, out_max, e.m);
      chk({nm, "_index"}, index, e.i);
      chk({nm, "_freq_index"}, freq_index, e.f);
    end
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    @(negedge clk);
    chk({nm, "_release"}, {s_axis_tvalid, busy}, 0);
  endtask

  vec_t tbl[6];
  vec_t zero_v;
  vec_t abort_v;

  initial begin
    tbl[0] = mk(5, 7, 100, -50, -1, 0, 0, 0, -1, 0, 0, 0,
                6250, 7, 5, 1'b0, 2);
    tbl[1] = mk(2, 3, 10, 10, 6, 3, 10, 10, 2, 8, 10, 10,
                100, 3, 2, 1'b0, 0);
    tbl[2] = mk(0, 0, -2048, -2048, -1, 0, 0, 0, -1, 0, 0, 0,
                4194304, 0, 0, 1'b0, 1);
    tbl[3] = mk(3, 9, 3, -5, 1, 4, -4, 0, 7, 0, 1, 1,
                16, 9, 3, 1'b1, 0);
    tbl[4] = mk(7, 9, -7, 2, 0, 0, 5, 0, -1, 0, 0, 0,
                26, 9, 7, 1'b0, 0);
    tbl[5] = mk(5, 7, 100, -50, -1, 0, 0, 0, -1, 0, 0, 0,
                6250, 7, 5, 1'b1, 5);
    zero_v = mk(-1, 0, 0, 0, -1, 0, 0, 0, -1, 0, 0, 0,
                0, 0, 0, 1'b0, 0);
    abort_v = mk(1, 2, 1000, 1000, 2, 6, -300, 7, -1, 0, 0, 0,
                 0, 0, 0, 1'b0, 0);

    rst = 1'b1;
    start = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    xi = '0;
    xq = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs",
        {s_axis_tready, s_axis_tvalid, out_max, index,
         freq_index, busy}, 0);

    for (int n = 0; n < 6; n++)
      run_sweep(tbl[n], -1, 1'b0, $sformatf("vec%0d", n));

    run_sweep(abort_v, 3, 1'b0, "abort");
    run_sweep(tbl[0], -1, 1'b0, "post_abort");
    run_sweep(zero_v, -1, 1'b1, "all_zero");

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
